gf_poly_mul_seq: RTL
====================

# gf_poly_mul_seq

Sequential GF(2^8) polynomial multiplier controller. It computes z(x) = p(x)·q(x) for two degree-n polynomials by scheduling all (n+1)^2 coefficient pairs through a single shared symbol multiplier and XOR-accumulating into the product register. It sits beside the combinational polynomial multiplier as the area-lean alternative for the RS/BCH datapath. It uses a valid/ready handshake on both sides.

## Interface
- m, 255: field order minus one
- SIZE, $clog2(m) = 8: symbol width
- n, 2: operand degree; n ≥ 1
- flat_size, (n+1)*SIZE: operand bus width
- large_array, 2*n: product degree
- large_array_size, (large_array+1)*SIZE: product bus width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- flat_p  in  flat_size  p; coefficient i at [i*SIZE +: SIZE]
- flat_q  in  flat_size  q; same packing
- out_valid  out  1  flat_z holds a finished product
- out_ready  in  1  consumer takes the product
- flat_z  out  large_array_size  z; coefficient k at [k*SIZE +: SIZE]
- busy  out  1  high in BUSY

## Operation
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (9'h11D). Addition is XOR.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. When in_valid is high, latch flat_p/flat_q, clear the accumulator, set i=j=0, and go to BUSY.
  - BUSY: each cycle, z[i+j] ^= gf_mul(p[i], q[j]). Then j increments; when j wraps at n, j returns to 0 and i increments. After the pair (n,n) is accumulated, go to DONE.
  - DONE: out_valid=1 and flat_z is stable. When out_ready is high, go to IDLE. flat_z keeps its value until the next accept.
- Changes on flat_p/flat_q outside the accept cycle are ignored.
- in_ready is 0 outside IDLE. An output handshake and a new accept never occur in the same cycle.
- Zero coefficients are not skipped; the cycle count is fixed.
- Width rules:
  - i, j: $clog2(n+1) bits.
  - Accumulator index i+j: range 0..2n.
  - gf_mul forms the 15-bit carry-less product, then reduces it mod 9'h11D.

## Timing
- Reset state: IDLE, in_ready=1, out_valid=0, busy=0, flat_z=0, i=j=0.
- Accept at edge E0. Pairs accumulate at edges E1..E(n+1)^2, which is E1..E9 for n=2.
- out_valid is high from the cycle after E(n+1)^2. Latency is (n+1)^2 + 1 cycles from the accept cycle to out_valid.
- Minimum initiation interval is (n+1)^2 + 2 cycles: BUSY, then one DONE cycle, then one IDLE cycle.
- out_valid is held indefinitely while out_ready=0.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- rst_n low in any state, including mid-BUSY: next state is IDLE with all reset values. The partial product is discarded.

## Structure
- Package gf_pkg contains:
  - GF_PRIM = 9'h11D
  - SYM_W = 8
  - state enum {IDLE, BUSY, DONE}
- Sub-module gf_mul: combinational SIZE×SIZE field multiplier. It is instantiated once and is reusable elsewhere.
- Controller: FSM, i/j counters, operand registers, accumulator array.

## Test plan
- Basic product: p=24'h040105, q=24'h020003 → flat_z=40'h080206030F. out_valid rises exactly 10 cycles after the accept cycle.
- Reduction: p=24'h000080, q=24'h000002 → flat_z=40'h000000001D. Also p=q=24'h0000FF → coefficient 0 = gf_mul(FF,FF)=8'hE2, all other coefficients 0.
- Backpressure: hold out_ready=0 for 20 cycles. out_valid and flat_z stay stable and in_ready stays 0. Raise out_ready: one handshake, IDLE on the next cycle, then the next operand pair is accepted.
- Operand isolation: change flat_p/flat_q and pulse in_valid during BUSY. The result equals the product of the latched operands, and no second accept occurs.
- Reset mid-op: drop rst_n at BUSY cycle 4. Next cycle shows IDLE, flat_z=0, out_valid=0. Then a fresh basic-product transaction completes correctly.
- Back-to-back: 100 random operand pairs with random out_ready. Each result matches a reference model, and the initiation interval is ≥ 11 cycles.

Source files
------------

// File: rtl/gf_pkg.sv
// -----------------------------------------------------------------------------
// gf_pkg
// Shared definitions for the GF(2^8) polynomial datapath.
//   GF_PRIM : primitive polynomial x^8+x^4+x^3+x^2+1
//   SYM_W   : symbol width in bits
//   state_t : controller states of the sequential polynomial multiplier
// -----------------------------------------------------------------------------
package gf_pkg;

    localparam logic [8:0] GF_PRIM = 9'h11D;
    localparam int         SYM_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gf_mul.sv
// -----------------------------------------------------------------------------
// gf_mul
// Combinational GF(2^8) symbol multiplier, y = a * b mod GF_PRIM.
// Ports:
//   a  in  SYM_W  multiplicand symbol
//   b  in  SYM_W  multiplier symbol
//   y  out SYM_W  field product
// -----------------------------------------------------------------------------
module gf_mul
    import gf_pkg::*;
(
    input  logic [SYM_W-1:0] a,
    input  logic [SYM_W-1:0] b,
    output logic [SYM_W-1:0] y
);

    // Carry-less product of two 8-bit symbols needs 15 bits.
    logic [2*SYM_W-2:0] prod;

    always_comb begin
        prod = '0;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) begin
                prod = prod ^ ({{(SYM_W-1){1'b0}}, a} << i);
            end
        end
        // Fold the high bits back in from the top down so each step only
        // touches bits below the one it clears.
        for (int k = 2*SYM_W-2; k >= SYM_W; k--) begin
            if (prod[k]) begin
                prod = prod ^ ({{(SYM_W-2){1'b0}}, GF_PRIM} << (k - SYM_W));
            end
        end
        y = prod[SYM_W-1:0];
    end

endmodule

// File: rtl/gf_poly_mul_seq.sv
// -----------------------------------------------------------------------------
// gf_poly_mul_seq
// Sequential GF(2^8) polynomial multiplier z(x) = p(x) * q(x). All (n+1)^2
// coefficient pairs are pushed through one shared gf_mul, one pair per cycle,
// and XOR-accumulated into the product coefficients.
//
// Ports:
//   clk        in   1                 rising-edge clock
//   rst_n      in   1                 synchronous active-low reset
//   in_valid   in   1                 operands present on flat_p/flat_q
//   in_ready   out  1                 high in IDLE only
//   flat_p     in   flat_size         p, coefficient i at [i*SIZE +: SIZE]
//   flat_q     in   flat_size         q, same packing
//   out_valid  out  1                 flat_z holds a finished product (DONE)
//   out_ready  in   1                 consumer takes the product
//   flat_z     out  large_array_size  z, coefficient k at [k*SIZE +: SIZE]
//   busy       out  1                 high in BUSY
//   dbg_state  out  state_t           current controller state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Input side: accept when in_valid && in_ready (IDLE only).
// Output side: hand-off when out_valid && out_ready (DONE only). in_ready and
// out_valid are never high together, so both transfers cannot share a cycle.
// A producer may not retract data it presents; the block simply ignores
// in_valid outside IDLE and out_ready outside DONE.
// -----------------------------------------------------------------------------
module gf_poly_mul_seq
    import gf_pkg::*;
#(
    parameter  int m                = 255,
    parameter  int n                = 2,
    localparam int SIZE             = $clog2(m),
    localparam int flat_size        = (n+1)*SIZE,
    localparam int large_array      = 2*n,
    localparam int large_array_size = (large_array+1)*SIZE
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [flat_size-1:0]        flat_p,
    input  logic [flat_size-1:0]        flat_q,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [large_array_size-1:0] flat_z,
    output logic                        busy,
    output state_t                      dbg_state
);

    localparam int IDX_W = $clog2(n+1);
    localparam int K_W   = $clog2(large_array+1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(n);

    state_t state, state_next;

    logic [IDX_W-1:0] i_idx, j_idx;
    logic [K_W-1:0]   k_idx;
    logic [SIZE-1:0]  p_reg [0:n];
    logic [SIZE-1:0]  q_reg [0:n];
    logic [SIZE-1:0]  acc   [0:large_array];
    logic [SIZE-1:0]  prod_sym;
    logic             last_pair;
    logic             accept;

    assign k_idx     = K_W'(i_idx) + K_W'(j_idx);
    assign last_pair = (i_idx == LAST) && (j_idx == LAST);
    assign dbg_state = state;

    gf_mul u_gf_mul (
        .a (p_reg[i_idx]),
        .b (q_reg[j_idx]),
        .y (prod_sym)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last_pair) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, pair counters and accumulator. The counters wrap to
    // zero on the last pair, so they are already cleared when DONE is entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_idx <= '0;
            j_idx <= '0;
            for (int k = 0; k <= n; k++) begin
                p_reg[k] <= '0;
                q_reg[k] <= '0;
            end
            for (int k = 0; k <= large_array; k++) begin
                acc[k] <= '0;
            end
        end else if (accept) begin
            i_idx <= '0;
            j_idx <= '0;
            for (int k = 0; k <= n; k++) begin
                p_reg[k] <= flat_p[k*SIZE +: SIZE];
                q_reg[k] <= flat_q[k*SIZE +: SIZE];
            end
            for (int k = 0; k <= large_array; k++) begin
                acc[k] <= '0;
            end
        end else if (state == BUSY) begin
            acc[k_idx] <= acc[k_idx] ^ prod_sym;
            if (j_idx == LAST) begin
                j_idx <= '0;
                i_idx <= (i_idx == LAST) ? '0 : i_idx + 1'b1;
            end else begin
                j_idx <= j_idx + 1'b1;
            end
        end
    end

    always_comb begin
        flat_z = '0;
        for (int k = 0; k <= large_array; k++) begin
            flat_z[k*SIZE +: SIZE] = acc[k];
        end
    end

endmodule
